// File: rtl/mips789_defs.sv
// Shared definitions for the data-memory path: read-owner encoding and write-enable width.
package mips789_defs;

   localparam int WE_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_EXT  = 2'd2
   } rd_own_e;

endpackage

// File: rtl/dmem_rd_router.sv
// Tracks which requester owns each in-flight RAM read and steers the returning data to it.
// Returns appear RD_LAT cycles after the grant; both returns are forced to 0 while rst is high.
module dmem_rd_router
   import mips789_defs::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_cpu_rd,
   input  logic        i_ext_rd,
   input  logic [31:0] i_ram_rdata,
   output logic        o_c_rvalid,
   output logic [31:0] o_c_rdata,
   output logic        o_x_rvalid,
   output logic [31:0] o_x_rdata
);

   rd_own_e r_rd_own [RD_LAT];
   rd_own_e w_own_nxt;
   rd_own_e w_rd_own;

   always_comb begin
      w_own_nxt = OWN_NONE;
      if (i_cpu_rd)
         w_own_nxt = OWN_CPU;
      else if (i_ext_rd)
         w_own_nxt = OWN_EXT;
   end

   // Each stage carries its own owner, so alternating back-to-back reads need no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++)
            r_rd_own[i] <= OWN_NONE;
      end else begin
         r_rd_own[0] <= w_own_nxt;
         for (int i = 1; i < RD_LAT; i++)
            r_rd_own[i] <= r_rd_own[i-1];
      end
   end

   assign w_rd_own   = r_rd_own[RD_LAT-1];
   assign o_c_rvalid = ~rst & (w_rd_own == OWN_CPU);
   assign o_x_rvalid = ~rst & (w_rd_own == OWN_EXT);
   assign o_c_rdata  = o_c_rvalid ? i_ram_rdata : 32'h0;
   assign o_x_rdata  = o_x_rvalid ? i_ram_rdata : 32'h0;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-RAM port between the CPU memory stage and an external requester; grants are same-cycle.
// Default: CPU priority with starvation override. Define DMEM_ARB_RR_EN for round-robin on contention.
module dmem_arbiter
   import mips789_defs::*;
#(
   parameter int STARVE_LIM = 8,
   parameter int RD_LAT     = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            c_req,
   input  logic [31:0]     c_addr,
   input  logic [WE_W-1:0] c_wr_en,
   input  logic [31:0]     c_dout,
   output logic            c_pause,
   output logic            c_rvalid,
   output logic [31:0]     c_rdata,
   input  logic            x_req,
   input  logic [31:0]     x_addr,
   input  logic [WE_W-1:0] x_wr_en,
   input  logic [31:0]     x_dout,
   output logic            x_gnt,
   output logic            x_rvalid,
   output logic [31:0]     x_rdata,
   output logic [31:0]     Zz_addr,
   output logic [31:0]     Zz_dout,
   output logic [WE_W-1:0] Zz_wr_en,
   input  logic [31:0]     zZ_din
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   logic [CNT_W-1:0] r_starve_cnt;
   logic             w_cpu_gnt;
   logic             w_ext_gnt;
   logic             w_starved;

`ifdef DMEM_ARB_RR_EN
   rd_own_e r_last_gnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_last_gnt <= OWN_EXT;
      else if (w_cpu_gnt)
         r_last_gnt <= OWN_CPU;
      else if (w_ext_gnt)
         r_last_gnt <= OWN_EXT;
   end
`endif

   assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIM));

   always_comb begin
      w_cpu_gnt = 1'b0;
      w_ext_gnt = 1'b0;
      if (!rst) begin
         if (c_req && x_req) begin
`ifdef DMEM_ARB_RR_EN
            if (r_last_gnt == OWN_CPU)
               w_ext_gnt = 1'b1;
            else
               w_cpu_gnt = 1'b1;
`else
            if (w_starved)
               w_ext_gnt = 1'b1;
            else
               w_cpu_gnt = 1'b1;
`endif
         end else begin
            w_cpu_gnt = c_req;
            w_ext_gnt = x_req;
         end
      end
   end

   assign c_pause  = c_req & ~w_cpu_gnt;
   assign x_gnt    = x_req & w_ext_gnt;
   // Idle cycles still present the CPU address/data; only the write strobe is suppressed.
   assign Zz_addr  = w_ext_gnt ? x_addr : c_addr;
   assign Zz_dout  = w_ext_gnt ? x_dout : c_dout;
   assign Zz_wr_en = w_ext_gnt ? x_wr_en : (w_cpu_gnt ? c_wr_en : '0);

   always_ff @(posedge clk) begin
      if (rst)
         r_starve_cnt <= '0;
      else if (x_req && !x_gnt)
         r_starve_cnt <= w_starved ? r_starve_cnt : r_starve_cnt + 1'b1;
      else
         r_starve_cnt <= '0;
   end

   dmem_rd_router #(
      .RD_LAT (RD_LAT)
   ) u_rd_router (
      .clk         (clk),
      .rst         (rst),
      .i_cpu_rd    (w_cpu_gnt & (c_wr_en == '0)),
      .i_ext_rd    (w_ext_gnt & (x_wr_en == '0)),
      .i_ram_rdata (zZ_din),
      .o_c_rvalid  (c_rvalid),
      .o_c_rdata   (c_rdata),
      .o_x_rvalid  (x_rvalid),
      .o_x_rdata   (x_rdata)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed checks of dmem_arbiter: vector table for single-cycle behaviour, hand sequences for starvation and reset.
module tb_dmem_arbiter;
   import mips789_defs::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req;
   logic [31:0] c_addr;
   logic [3:0]  c_wr_en;
   logic [31:0] c_dout;
   logic        c_pause;
   logic        c_rvalid;
   logic [31:0] c_rdata;
   logic        x_req;
   logic [31:0] x_addr;
   logic [3:0]  x_wr_en;
   logic [31:0] x_dout;
   logic        x_gnt;
   logic        x_rvalid;
   logic [31:0] x_rdata;
   logic [31:0] Zz_addr;
   logic [31:0] Zz_dout;
   logic [3:0]  Zz_wr_en;
   logic [31:0] zZ_din;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIM(8), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_addr(c_addr), .c_wr_en(c_wr_en), .c_dout(c_dout),
      .c_pause(c_pause), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .x_req(x_req), .x_addr(x_addr), .x_wr_en(x_wr_en), .x_dout(x_dout),
      .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
      .Zz_addr(Zz_addr), .Zz_dout(Zz_dout), .Zz_wr_en(Zz_wr_en), .zZ_din(zZ_din)
   );

   typedef struct {
      logic        c_req;
      logic [31:0] c_addr;
      logic [3:0]  c_we;
      logic [31:0] c_dout;
      logic        x_req;
      logic [31:0] x_addr;
      logic [3:0]  x_we;
      logic [31:0] x_dout;
      logic [31:0] din;
      logic        e_pause;
      logic        e_xgnt;
      logic [31:0] e_addr;
      logic [31:0] e_dout;
      logic [3:0]  e_we;
      logic        e_crv;
      logic [31:0] e_crd;
      logic        e_xrv;
      logic [31:0] e_xrd;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      c_req = 0; c_addr = 0; c_wr_en = 0; c_dout = 0;
      x_req = 0; x_addr = 0; x_wr_en = 0; x_dout = 0;
      zZ_din = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   initial begin
      //         c_req c_addr        cwe   c_dout        x_req x_addr        xwe   x_dout        din            pause xgnt addr          dout          we    crv crd           xrv xrd
      vecs[0]  = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   4'h0, 32'h0,    32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
      vecs[1]  = '{1, 32'h100, 4'h0, 32'h0,        0, 32'h0,   4'h0, 32'h0,    32'h0,        0, 0, 32'h100, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
      vecs[2]  = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   4'h0, 32'h0,    32'h11223344, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h11223344, 0, 32'h0};
      vecs[3]  = '{1, 32'h200, 4'hF, 32'hDEADBEEF, 1, 32'h300, 4'h0, 32'h0,    32'h0,        0, 0, 32'h200, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 32'h0};
      vecs[4]  = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   4'h0, 32'h0,    32'hAAAA5555, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
      vecs[5]  = '{0, 32'h0,   4'h0, 32'h0,        1, 32'h400, 4'h0, 32'h0,    32'h0,        0, 1, 32'h400, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
      vecs[6]  = '{1, 32'h104, 4'h0, 32'h0,        0, 32'h0,   4'h0, 32'h0,    32'h0E0E0E0E, 0, 0, 32'h104, 32'h0,        4'h0, 0, 32'h0,        1, 32'h0E0E0E0E};
      vecs[7]  = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   4'h0, 32'h0,    32'h0C0C0C0C, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h0C0C0C0C, 0, 32'h0};
      vecs[8]  = '{0, 32'h0,   4'h0, 32'h0,        1, 32'h500, 4'h3, 32'h1234, 32'h0,        0, 1, 32'h500, 32'h1234,     4'h3, 0, 32'h0,        0, 32'h0};
      vecs[9]  = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   4'h0, 32'h0,    32'hFFFFFFFF, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
      vecs[10] = '{1, 32'h10,  4'h0, 32'h0,        1, 32'h20,  4'h0, 32'h0,    32'h0,        0, 0, 32'h10,  32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
      vecs[11] = '{0, 32'h0,   4'h0, 32'h0,        1, 32'h24,  4'h0, 32'h0,    32'h77,       0, 1, 32'h24,  32'h0,        4'h0, 1, 32'h77,       0, 32'h0};
      vecs[12] = '{0, 32'h0,   4'h0, 32'h0,        0, 32'h0,   4'h0, 32'h0,    32'h88,       0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1, 32'h88};

      // Reset behaviour with both requesters active.
      idle_inputs();
      rst = 1;
      c_req = 1; c_addr = 32'h40; c_wr_en = 4'hF;
      x_req = 1; x_addr = 32'h80; x_wr_en = 4'hF;
      step();
      chk("rst_x_gnt",    {31'd0, x_gnt},    32'd0);
      chk("rst_we",       {28'd0, Zz_wr_en}, 32'd0);
      chk("rst_c_rvalid", {31'd0, c_rvalid}, 32'd0);
      chk("rst_x_rvalid", {31'd0, x_rvalid}, 32'd0);
      chk("rst_starve",   32'(dut.r_starve_cnt), 32'd0);
      chk("rst_rd_own",   32'(dut.u_rd_router.r_rd_own[0]), 32'(OWN_NONE));
      do_reset();

      for (int i = 0; i < 13; i++) begin
         c_req = vecs[i].c_req; c_addr = vecs[i].c_addr; c_wr_en = vecs[i].c_we; c_dout = vecs[i].c_dout;
         x_req = vecs[i].x_req; x_addr = vecs[i].x_addr; x_wr_en = vecs[i].x_we; x_dout = vecs[i].x_dout;
         zZ_din = vecs[i].din;
         #3;
         chk($sformatf("v%0d_pause", i),  {31'd0, c_pause},  {31'd0, vecs[i].e_pause});
         chk($sformatf("v%0d_xgnt", i),   {31'd0, x_gnt},    {31'd0, vecs[i].e_xgnt});
         chk($sformatf("v%0d_addr", i),   Zz_addr,           vecs[i].e_addr);
         chk($sformatf("v%0d_dout", i),   Zz_dout,           vecs[i].e_dout);
         chk($sformatf("v%0d_we", i),     {28'd0, Zz_wr_en}, {28'd0, vecs[i].e_we});
         chk($sformatf("v%0d_crv", i),    {31'd0, c_rvalid}, {31'd0, vecs[i].e_crv});
         chk($sformatf("v%0d_crd", i),    c_rdata,           vecs[i].e_crd);
         chk($sformatf("v%0d_xrv", i),    {31'd0, x_rvalid}, {31'd0, vecs[i].e_xrv});
         chk($sformatf("v%0d_xrd", i),    x_rdata,           vecs[i].e_xrd);
         step();
      end

      // Continuous contention: CPU wins until the external port has waited STARVE_LIM cycles.
      do_reset();
      c_req = 1; c_addr = 32'h10;
      x_req = 1; x_addr = 32'h20;
      for (int k = 1; k <= 10; k++) begin
         logic exp_x;
`ifdef DMEM_ARB_RR_EN
         exp_x = (k % 2 == 0);
`else
         exp_x = (k == 9);
`endif
         #3;
         chk($sformatf("cont%0d_xgnt", k),  {31'd0, x_gnt},   {31'd0, exp_x});
         chk($sformatf("cont%0d_pause", k), {31'd0, c_pause}, {31'd0, exp_x});
         chk($sformatf("cont%0d_addr", k),  Zz_addr, exp_x ? 32'h20 : 32'h10);
`ifndef DMEM_ARB_RR_EN
         if (k == 9)
            chk("cont9_starve", 32'(dut.r_starve_cnt), 32'd8);
`endif
         step();
`ifndef DMEM_ARB_RR_EN
         if (k == 9)
            chk("cont9_starve_clr", 32'(dut.r_starve_cnt), 32'd0);
`endif
      end

      // Reset the cycle after an external read grant drops the return.
      do_reset();
      x_req = 1; x_addr = 32'h600;
      #3;
      chk("rd_rst_gnt", {31'd0, x_gnt}, 32'd1);
      step();
      rst = 1;
      x_wr_en = 4'hF; zZ_din = 32'h5A5A5A5A;
      #3;
      chk("rd_rst_xrv",  {31'd0, x_rvalid}, 32'd0);
      chk("rd_rst_xrd",  x_rdata, 32'd0);
      chk("rd_rst_we",   {28'd0, Zz_wr_en}, 32'd0);
      chk("rd_rst_xgnt", {31'd0, x_gnt}, 32'd0);
      step();
      rst = 0;
      idle_inputs();
      zZ_din = 32'h5A5A5A5A;
      #3;
      chk("rd_rst_own",   32'(dut.u_rd_router.r_rd_own[0]), 32'(OWN_NONE));
      chk("rd_rst_xrv2",  {31'd0, x_rvalid}, 32'd0);
      chk("rd_rst_crv2",  {31'd0, c_rvalid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
